lpf_stream: RTL and testbench

Parametrised successor to the fixed two-pixels-per-word LPF reader. It streams one frame in raster order from frame memory to the projective transform, one pixel per consumer request. It supports a configurable pixel width, pixels per memory word and image size. It adds a runtime-selectable horizontal [1 2 1]/4 low-pass filter with edge replication. It sits between the memory interface (read port) and projective_transform.

---
 rtl/lpf_stream_pkg.sv | 19 +
 rtl/lpf_stream_if.sv | 33 +++
 rtl/lpf_stream_window.sv | 57 +++++
 rtl/lpf_stream.sv | 159 +++++++++++++++
 tb/tb_lpf_stream.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpf_stream_pkg.sv
// Shared defaults and FSM encoding for the raster low-pass stream reader.
package lpf_stream_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_PIX_W  = 9;
  localparam int DEF_PPW    = 2;
  localparam int DEF_X_W    = 10;
  localparam int DEF_Y_W    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_SHIFT,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/lpf_stream_if.sv
// Memory read port plus consumer pixel stream; master is the reader block.
interface lpf_stream_if
  import lpf_stream_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int PPW   = DEF_PPW,
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W
);

  logic                 lpf_flag;
  logic [X_W-1:0]       lpf_x;
  logic [Y_W-1:0]       lpf_y;
  logic                 done_lpf;
  logic [PPW*PIX_W-1:0] lpf_pixel_read;
  logic                 request;
  logic                 ready;
  logic [PIX_W-1:0]     pixel;
  logic [X_W-1:0]       x_out;
  logic [Y_W-1:0]       y_out;
  logic                 pixel_flag;

  modport master (
    output lpf_flag, lpf_x, lpf_y, ready, pixel, x_out, y_out, pixel_flag,
    input  done_lpf, lpf_pixel_read, request
  );

  modport slave (
    input  lpf_flag, lpf_x, lpf_y, ready, pixel, x_out, y_out, pixel_flag,
    output done_lpf, lpf_pixel_read, request
  );

endinterface

// File: rtl/lpf_stream_window.sv
// Three-pixel horizontal window with replicate-on-load and a registered
// [1 2 1]/4 or bypass result.
module lpf_stream_window
  import lpf_stream_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift,
  input  logic             load_first,
  input  logic             repl,
  input  logic             filt,
  input  logic             calc,
  input  logic [PIX_W-1:0] in_pix,
  output logic [PIX_W-1:0] result
);

  logic [PIX_W-1:0] prev_p0, cur_p0, next_p0;
  logic [PIX_W-1:0] result_p1;

  // 4*max+2 fits in PIX_W+2 bits, so the shifted sum never overflows PIX_W
  function automatic logic [PIX_W-1:0] smooth(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c);
    logic [PIX_W+1:0] acc;
    acc = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + (PIX_W+2)'(2);
    return acc[PIX_W+1:2];
  endfunction

  // window stage
  always_ff @(posedge clock) begin
    if (shift) begin
      if (load_first) begin
        prev_p0 <= in_pix;
        cur_p0  <= in_pix;
        next_p0 <= in_pix;
      end else begin
        prev_p0 <= cur_p0;
        cur_p0  <= next_p0;
        next_p0 <= repl ? next_p0 : in_pix;
      end
    end
  end

  // result stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_p1 <= '0;
    end else if (calc) begin
      result_p1 <= filt ? smooth(prev_p0, cur_p0, next_p0) : cur_p0;
    end
  end

  assign result = result_p1;

endmodule

// File: rtl/lpf_stream.sv
// Raster-order frame reader: fetches packed words on demand and emits one
// optionally low-passed pixel per consumer request.
module lpf_stream
  import lpf_stream_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int PPW    = DEF_PPW,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_flag,
  input  logic          filter_en,
  lpf_stream_if.master  bus
);

  localparam logic [X_W-1:0] PPW_X  = X_W'(PPW);
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  state_t               state;
  logic [X_W-1:0]       x, src, buf_idx, lpf_x_r, x_out_r;
  logic [Y_W-1:0]       y, lpf_y_r, y_out_r;
  logic [PPW*PIX_W-1:0] buf_word;
  logic                 buf_valid, first, repl, filt_row;
  logic                 lpf_flag_r, ready_r, pixel_flag_r;
  logic [X_W-1:0]       word_idx, slot;
  logic [PIX_W-1:0]     sel_pix, result;
  logic                 shift_en, calc_en;

  assign word_idx = src / PPW_X;
  assign slot     = src % PPW_X;
  assign shift_en = (state == ST_SHIFT) && !frame_flag;
  assign calc_en  = (state == ST_EMIT) && !frame_flag;

  // slot 0 sits in the most significant bits of the word
  always_comb begin
    sel_pix = '0;
    for (int j = 0; j < PPW; j++) begin
      if (slot == X_W'(j)) sel_pix = buf_word[(PPW-j)*PIX_W-1 -: PIX_W];
    end
  end

  always_ff @(posedge clock) begin
    if (state == ST_FETCH && bus.done_lpf && !frame_flag) buf_word <= bus.lpf_pixel_read;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      x            <= '0;
      y            <= '0;
      src          <= '0;
      buf_idx      <= '0;
      buf_valid    <= 1'b0;
      first        <= 1'b0;
      repl         <= 1'b0;
      filt_row     <= 1'b0;
      lpf_flag_r   <= 1'b0;
      lpf_x_r      <= '0;
      lpf_y_r      <= '0;
      ready_r      <= 1'b1;
      pixel_flag_r <= 1'b0;
      x_out_r      <= '0;
      y_out_r      <= '0;
    end else begin
      pixel_flag_r <= 1'b0;
      if (frame_flag) begin
        state      <= ST_IDLE;
        x          <= '0;
        y          <= '0;
        buf_valid  <= 1'b0;
        lpf_flag_r <= 1'b0;
        ready_r    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (bus.request) begin
            ready_r <= 1'b0;
            state   <= ST_LOAD;
            first   <= (x == '0);
            repl    <= (x == X_LAST);
            src     <= (x == '0) ? '0 : x + X_W'(1);
            if (x == '0) filt_row <= filter_en;
          end
          ST_LOAD: begin
            if (repl || (buf_valid && buf_idx == word_idx)) begin
              state <= ST_SHIFT;
            end else begin
              lpf_x_r    <= word_idx;
              lpf_y_r    <= y;
              lpf_flag_r <= 1'b1;
              state      <= ST_FETCH;
            end
          end
          ST_FETCH: if (bus.done_lpf) begin
            buf_idx    <= lpf_x_r;
            buf_valid  <= 1'b1;
            lpf_flag_r <= 1'b0;
            state      <= ST_SHIFT;
          end
          // row start needs pixel 0 replicated, then pixel 1 shifted in
          ST_SHIFT: begin
            if (first) begin
              first <= 1'b0;
              src   <= X_W'(1);
              state <= ST_LOAD;
            end else begin
              state <= ST_EMIT;
            end
          end
          ST_EMIT: begin
            pixel_flag_r <= 1'b1;
            x_out_r      <= x;
            y_out_r      <= y;
            ready_r      <= 1'b1;
            state        <= ST_IDLE;
            if (x == X_LAST) begin
              x         <= '0;
              buf_valid <= 1'b0;
              y         <= (y == Y_LAST) ? '0 : y + Y_W'(1);
            end else begin
              x <= x + X_W'(1);
            end
          end
          default: begin
            state      <= ST_IDLE;
            lpf_flag_r <= 1'b0;
            ready_r    <= 1'b1;
          end
        endcase
      end
    end
  end

  lpf_stream_window #(.PIX_W(PIX_W)) u_window (
    .clock      (clock),
    .reset      (reset),
    .shift      (shift_en),
    .load_first (first),
    .repl       (repl),
    .filt       (filt_row),
    .calc       (calc_en),
    .in_pix     (sel_pix),
    .result     (result)
  );

  assign bus.lpf_flag   = lpf_flag_r;
  assign bus.lpf_x      = lpf_x_r;
  assign bus.lpf_y      = lpf_y_r;
  assign bus.ready      = ready_r;
  assign bus.pixel      = result;
  assign bus.x_out      = x_out_r;
  assign bus.y_out      = y_out_r;
  assign bus.pixel_flag = pixel_flag_r;

endmodule

// File: tb/tb_lpf_stream.sv
// Directed bench for lpf_stream on an 8x2 image with a 3-cycle memory model.
module tb_lpf_stream;

  logic clock, reset, frame_flag, filter_en;
  int   checks, errors;
  int   pix_cnt, fetch_cnt, lat_cnt;
  int   fetch_x [0:63];
  int   got_pix, got_x, got_y, last_lat;
  logic lpf_prev, flag_prev;

  lpf_stream_if #(.PIX_W(9), .PPW(2), .X_W(10), .Y_W(9)) bus ();

  lpf_stream #(.WIDTH(8), .HEIGHT(2), .PIX_W(9), .PPW(2), .X_W(10), .Y_W(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_flag (frame_flag),
    .filter_en  (filter_en),
    .bus        (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Row 0 pixels are 10,20,..,80; row 1 pixels are 100,110,..,170.
  function automatic logic [17:0] mem_word(input int lx, input int ly);
    int a, b;
    a = ((ly == 0) ? 10 : 100) + 20 * lx;
    b = a + 10;
    return {a[8:0], b[8:0]};
  endfunction

  // Memory responder and pixel monitor.
  initial begin
    bus.done_lpf = 1'b0;
    bus.lpf_pixel_read = '0;
    lat_cnt = 0; lpf_prev = 1'b0; flag_prev = 1'b0;
    forever begin
      @(negedge clock);
      bus.done_lpf = 1'b0;
      if (bus.lpf_flag) begin
        if (!lpf_prev) begin
          if (fetch_cnt < 64) fetch_x[fetch_cnt] = int'(bus.lpf_x);
          fetch_cnt++;
        end
        lat_cnt++;
        if (lat_cnt == 3) begin
          bus.done_lpf = 1'b1;
          bus.lpf_pixel_read = mem_word(int'(bus.lpf_x), int'(bus.lpf_y));
          lat_cnt = 0;
        end
      end else begin
        lat_cnt = 0;
      end
      lpf_prev = bus.lpf_flag;
      if (bus.pixel_flag) begin
        pix_cnt++;
        checks++;
        if (flag_prev) begin
          errors++;
          $display("FAIL pixel_flag_gap got two consecutive high cycles, required at most one");
        end
      end
      flag_prev = bus.pixel_flag;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic do_req();
    bus.request = 1'b1;
    @(negedge clock);
    bus.request = 1'b0;
    last_lat = 1;
    while (bus.pixel_flag !== 1'b1 && last_lat < 60) begin
      @(negedge clock);
      last_lat++;
    end
    got_pix = int'(bus.pixel);
    got_x   = int'(bus.x_out);
    got_y   = int'(bus.y_out);
    checks++;
    if (bus.pixel_flag !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout got no pixel_flag in %0d cycles, required within 60", last_lat);
    end
  endtask

  task automatic check_pix(input string name, input int ep, input int ex, input int ey);
    checks += 3;
    if (got_pix !== ep) begin errors++; $display("FAIL %s_pixel got %0d exp %0d", name, got_pix, ep); end
    if (got_x !== ex) begin errors++; $display("FAIL %s_x got %0d exp %0d", name, got_x, ex); end
    if (got_y !== ey) begin errors++; $display("FAIL %s_y got %0d exp %0d", name, got_y, ey); end
  endtask

  task automatic wait_fetch(output bit ok);
    int n;
    n = 0;
    while (bus.lpf_flag !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    ok = (bus.lpf_flag === 1'b1);
    checks++;
    if (!ok) begin errors++; $display("FAIL fetch_timeout got lpf_flag=0 after %0d cycles, required 1", n); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks += 7;
    if (bus.ready !== 1'b1)      begin errors++; $display("FAIL rst_ready got %b exp 1", bus.ready); end
    if (bus.lpf_flag !== 1'b0)   begin errors++; $display("FAIL rst_lpf_flag got %b exp 0", bus.lpf_flag); end
    if (bus.pixel_flag !== 1'b0) begin errors++; $display("FAIL rst_pixel_flag got %b exp 0", bus.pixel_flag); end
    if (bus.pixel !== 9'd0)      begin errors++; $display("FAIL rst_pixel got %0d exp 0", bus.pixel); end
    if (bus.x_out !== 10'd0)     begin errors++; $display("FAIL rst_x_out got %0d exp 0", bus.x_out); end
    if (bus.y_out !== 9'd0)      begin errors++; $display("FAIL rst_y_out got %0d exp 0", bus.y_out); end
    if (bus.lpf_x !== 10'd0)     begin errors++; $display("FAIL rst_lpf_x got %0d exp 0", bus.lpf_x); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_bypass();
    int f0, ep;
    filter_en = 1'b0;
    f0 = fetch_cnt;
    for (int i = 0; i < 16; i++) begin
      ep = (i < 8) ? 10 + 10 * i : 100 + 10 * (i - 8);
      do_req();
      check_pix("bypass", ep, i % 8, i / 8);
      if (i == 2 || i == 7) begin
        checks++;
        if (last_lat !== 4) begin errors++; $display("FAIL bypass_latency x=%0d got %0d exp 4", i, last_lat); end
      end
      repeat (2) @(negedge clock);
    end
    checks++;
    if (fetch_cnt - f0 !== 8) begin errors++; $display("FAIL bypass_fetch_count got %0d exp 8", fetch_cnt - f0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (fetch_x[f0+i] !== i % 4) begin
        errors++; $display("FAIL bypass_lpf_x[%0d] got %0d exp %0d", i, fetch_x[f0+i], i % 4);
      end
    end
  endtask

  task automatic test_wrap();
    do_req();
    check_pix("wrap", 10, 0, 0);
    @(negedge clock);
  endtask

  task automatic test_frame_request_same();
    int c0;
    @(negedge clock);
    c0 = pix_cnt;
    frame_flag = 1'b1;
    bus.request = 1'b1;
    @(negedge clock);
    frame_flag = 1'b0;
    bus.request = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (pix_cnt !== c0) begin errors++; $display("FAIL frame_req_same_pixels got %0d exp %0d", pix_cnt, c0); end
  endtask

  task automatic test_filter();
    int exp_f [0:7];
    int f0;
    exp_f = '{13, 20, 30, 40, 50, 60, 70, 78};
    filter_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) f0 = fetch_cnt;
      do_req();
      if (i == 0) filter_en = 1'b0;
      check_pix("filter", exp_f[i], i, 0);
      @(negedge clock);
    end
    checks += 2;
    if (fetch_cnt !== f0) begin errors++; $display("FAIL filter_x7_fetch got %0d fetches exp 0", fetch_cnt - f0); end
    if (last_lat !== 4) begin errors++; $display("FAIL filter_x7_latency got %0d exp 4", last_lat); end
  endtask

  task automatic test_ready_ignore();
    int c0, n;
    bit ok;
    @(negedge clock);
    c0 = pix_cnt;
    bus.request = 1'b1;
    @(negedge clock);
    bus.request = 1'b0;
    wait_fetch(ok);
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b exp 0", bus.ready); end
    bus.request = 1'b1;
    @(negedge clock);
    bus.request = 1'b0;
    n = 0;
    while (bus.pixel_flag !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    got_pix = int'(bus.pixel); got_x = int'(bus.x_out); got_y = int'(bus.y_out);
    check_pix("busy", 100, 0, 1);
    repeat (15) @(negedge clock);
    checks++;
    if (pix_cnt !== c0 + 1) begin errors++; $display("FAIL busy_pixel_count got %0d exp %0d", pix_cnt - c0, 1); end
    do_req();
    check_pix("busy_next", 110, 1, 1);
    @(negedge clock);
  endtask

  task automatic test_frame_flag();
    int c0;
    bit ok;
    do_req();
    check_pix("frame_pre", 120, 2, 1);
    @(negedge clock);
    c0 = pix_cnt;
    bus.request = 1'b1;
    @(negedge clock);
    bus.request = 1'b0;
    wait_fetch(ok);
    frame_flag = 1'b1;
    @(negedge clock);
    frame_flag = 1'b0;
    checks += 2;
    if (bus.lpf_flag !== 1'b0) begin errors++; $display("FAIL frame_lpf_flag got %b exp 0", bus.lpf_flag); end
    if (bus.ready !== 1'b1)    begin errors++; $display("FAIL frame_ready got %b exp 1", bus.ready); end
    repeat (12) @(negedge clock);
    checks++;
    if (pix_cnt !== c0) begin errors++; $display("FAIL frame_dropped got %0d pixels exp 0", pix_cnt - c0); end
    do_req();
    check_pix("frame_restart", 10, 0, 0);
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.request = 1'b1;
    @(negedge clock);
    bus.request = 1'b0;
    wait_fetch(ok);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (bus.lpf_flag !== 1'b0)   begin errors++; $display("FAIL rstmid_lpf_flag got %b exp 0", bus.lpf_flag); end
    if (bus.ready !== 1'b1)      begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.ready); end
    if (bus.pixel !== 9'd0)      begin errors++; $display("FAIL rstmid_pixel got %0d exp 0", bus.pixel); end
    if (bus.pixel_flag !== 1'b0) begin errors++; $display("FAIL rstmid_pixel_flag got %b exp 0", bus.pixel_flag); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_req();
    check_pix("rstmid_restart", 10, 0, 0);
  endtask

  initial begin
    checks = 0; errors = 0; pix_cnt = 0; fetch_cnt = 0;
    got_pix = 0; got_x = 0; got_y = 0; last_lat = 0;
    reset = 1'b0; frame_flag = 1'b0; filter_en = 1'b0; bus.request = 1'b0;
    test_reset();
    test_bypass();
    test_wrap();
    test_frame_request_same();
    test_filter();
    test_ready_ignore();
    test_frame_flag();
    test_reset_mid();
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
